// File: rtl/key_expand_seq_if.sv
// Key-expansion bus: start/Key request side and the round-key schedule result side.
// The design uses the slave modport; a key source or testbench uses master.
interface key_expand_seq_if #(
    parameter int nk = 4,
    parameter int nr = 10
);
    logic                     start;
    logic [0:32*nk-1]         Key;
    logic [0:128*(nr+1)-1]    keySchedule;
    logic                     busy;
    logic                     done;

    modport master (
        output start,
        output Key,
        input  keySchedule,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  Key,
        output keySchedule,
        output busy,
        output done
    );
endinterface

// File: rtl/key_expand_seq.sv
// Sequential AES key expansion: one 32-bit schedule word per clock, schedule held until restart.
// Supports AES-128/192/256 through nk/nr.
module key_expand_seq #(
    parameter int nk = 4,
    parameter int nr = 10
) (
    input  logic             clk,
    input  logic             reset,
    key_expand_seq_if.slave  bus
);
    localparam int          NW  = 4 * (nr + 1);
    localparam logic [5:0]  NK6 = 6'(nk);
    localparam logic [5:0]  NW6 = 6'(NW);
    localparam logic [3:0]  NK4 = 4'(nk);

    // Forward S-box, byte b at bits [8*b +: 8].
    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic [7:0] sbox_byte(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] t);
        return {sbox_byte(t[31:24]), sbox_byte(t[23:16]), sbox_byte(t[15:8]), sbox_byte(t[7:0])};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t       r_state;
    state_t       w_next_state;
    logic [5:0]   r_cnt;
    logic [3:0]   r_mod;
    logic [7:0]   r_rcon;
    logic         r_busy;
    logic         r_done;
    logic [31:0]  r_w [0:NW-1];

    logic         w_load;
    logic         w_step;
    logic [31:0]  w_prev;
    logic [31:0]  w_back;
    logic [31:0]  w_sub_in;
    logic [31:0]  w_sub;
    logic [31:0]  w_temp;
    logic [31:0]  w_new;
    logic [7:0]   w_rcon_next;

    // Next-word datapath; a single SubWord is shared between the rcon and nk=8 mid-key cases.
    always_comb begin
        w_prev      = r_w[r_cnt - 6'd1];
        w_back      = r_w[r_cnt - NK6];
        w_sub_in    = w_prev;
        w_temp      = w_prev;
        w_rcon_next = r_rcon;
        if (r_mod == 4'd0) begin
            w_sub_in = {w_prev[23:0], w_prev[31:24]};
        end else begin
            w_sub_in = w_prev;
        end
        w_sub = sub_word(w_sub_in);
        if (r_mod == 4'd0) begin
            w_temp      = w_sub ^ {r_rcon, 24'h000000};
            w_rcon_next = xtime(r_rcon);
        end else if ((nk > 6) && (r_mod == 4'd4)) begin
            w_temp = w_sub;
        end else begin
            w_temp = w_prev;
        end
        w_new = w_back ^ w_temp;
    end

    // Next-state logic: start is honoured only from IDLE or DONE.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_step       = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.start) begin
                    w_next_state = S_RUN;
                    w_load       = 1'b1;
                end else begin
                    w_next_state = r_state;
                end
            end
            S_RUN: begin
                w_step = 1'b1;
                if (r_cnt == NW6 - 6'd1) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RUN;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // State, counters and schedule storage; reset clears the whole schedule.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 6'd0;
            r_mod   <= 4'd0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            for (int i = 0; i < NW; i++) begin
                r_w[i] <= 32'h00000000;
            end
        end else begin
            r_state <= w_next_state;
            r_busy  <= (w_next_state == S_RUN);
            r_done  <= (w_next_state == S_DONE);
            if (w_load) begin
                for (int i = 0; i < nk; i++) begin
                    r_w[i] <= bus.Key[32*i +: 32];
                end
                r_cnt  <= NK6;
                r_mod  <= 4'd0;
                r_rcon <= 8'h01;
            end else if (w_step) begin
                r_w[r_cnt] <= w_new;
                r_cnt      <= r_cnt + 6'd1;
                r_mod      <= (r_mod == NK4 - 4'd1) ? 4'd0 : r_mod + 4'd1;
                r_rcon     <= w_rcon_next;
            end
        end
    end

    for (genvar j = 0; j < NW; j++) begin : g_out
        assign bus.keySchedule[32*j +: 32] = r_w[j];
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;

endmodule

// File: tb/tb_key_expand_seq.sv
// Scoreboard bench for key_expand_seq: AES-128/192/256 instances checked against a
// GF(2^8)-derived reference key expansion plus published known-answer round keys.
module tb_key_expand_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    key_expand_seq_if #(.nk(4), .nr(10)) if4 ();
    key_expand_seq_if #(.nk(6), .nr(12)) if6 ();
    key_expand_seq_if #(.nk(8), .nr(14)) if8 ();

    key_expand_seq #(.nk(4), .nr(10)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    key_expand_seq #(.nk(6), .nr(12)) dut6 (.clk(clk), .reset(reset), .bus(if6));
    key_expand_seq #(.nk(8), .nr(14)) dut8 (.clk(clk), .reset(reset), .bus(if8));

    typedef struct {
        logic [0:1919] sched;
        int            due;
    } exp_t;

    exp_t q4[$];
    exp_t q6[$];
    exp_t q8[$];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [7:0] sbox [256];
    logic p4 = 1'b0, p6 = 1'b0, p8 = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d = {b, b};
        return d[15-n -: 8];
    endfunction

    // S-box from its definition: multiplicative inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
    endfunction

    function automatic logic [0:1919] expand(input logic [255:0] key, input int nk);
        logic [31:0] w [60];
        logic [0:1919] r = '0;
        logic [7:0] rc = 8'h01;
        logic [31:0] t;
        int nw = 4 * (nk + 7);
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < nw; i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int i = 0; i < nw; i++) r[32*i +: 32] = w[i];
        return r;
    endfunction

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic cmp_sched(input string name, input logic [0:1919] got, input logic [0:1919] exp);
        int bad = -1;
        tests++;
        for (int j = 0; j < 60; j++) begin
            if (bad < 0 && got[32*j +: 32] !== exp[32*j +: 32]) bad = j;
        end
        if (bad >= 0) begin
            fails++;
            $display("FAIL %s: word %0d got %h expected %h", name, bad, got[32*bad +: 32], exp[32*bad +: 32]);
        end
    endtask

    // Monitor: pop and compare on each rising done; busy and done must never overlap.
    always @(negedge clk) begin
        exp_t e;
        if (if4.done === 1'b1 && p4 !== 1'b1) begin
            if (q4.size() == 0) begin
                tests++; fails++; $display("FAIL done4_unexpected: got done=1 expected none pending");
            end else begin
                e = q4.pop_front();
                cmp_sched("sched4", {if4.keySchedule, 512'b0}, e.sched);
                check("latency4", cyc, e.due);
            end
        end
        if (if6.done === 1'b1 && p6 !== 1'b1) begin
            if (q6.size() == 0) begin
                tests++; fails++; $display("FAIL done6_unexpected: got done=1 expected none pending");
            end else begin
                e = q6.pop_front();
                cmp_sched("sched6", {if6.keySchedule, 256'b0}, e.sched);
                check("latency6", cyc, e.due);
            end
        end
        if (if8.done === 1'b1 && p8 !== 1'b1) begin
            if (q8.size() == 0) begin
                tests++; fails++; $display("FAIL done8_unexpected: got done=1 expected none pending");
            end else begin
                e = q8.pop_front();
                cmp_sched("sched8", if8.keySchedule, e.sched);
                check("latency8", cyc, e.due);
            end
        end
        if ((if4.busy & if4.done) === 1'b1 || (if6.busy & if6.done) === 1'b1 || (if8.busy & if8.done) === 1'b1) begin
            tests++; fails++; $display("FAIL busy_done_overlap: got both high expected exclusive");
        end
        p4 = if4.done;
        p6 = if6.done;
        p8 = if8.done;
    end

    function automatic logic done_of(input int id);
        case (id)
            4:       return if4.done;
            6:       return if6.done;
            default: return if8.done;
        endcase
    endfunction

    // Drive a one-cycle start; push the expected schedule only if it should be accepted.
    task automatic issue(input int id, input logic [255:0] key, input bit accept);
        exp_t e;
        @(negedge clk);
        case (id)
            4:       begin if4.Key = key[255 -: 128]; if4.start = 1'b1; end
            6:       begin if6.Key = key[255 -: 192]; if6.start = 1'b1; end
            default: begin if8.Key = key;             if8.start = 1'b1; end
        endcase
        @(posedge clk);
        #1;
        if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0;
        if4.Key = {$urandom, $urandom, $urandom, $urandom};
        if6.Key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if8.Key = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        if (accept) begin
            e.sched = expand(key, id);
            e.due   = cyc + 4 * (id + 7) - id;
            case (id)
                4:       q4.push_back(e);
                6:       q6.push_back(e);
                default: q8.push_back(e);
            endcase
        end
    endtask

    task automatic wait_done(input int id, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done_of(id) !== 1'b1 && n < budget);
        if (done_of(id) !== 1'b1) begin
            tests++; fails++;
            $display("FAIL timeout%0d: got no done within %0d cycles expected done", id, budget);
        end
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        logic [255:0] k;
        build_sbox();
        reset = 1'b1;
        if4.start = 1'b0; if6.start = 1'b0; if8.start = 1'b0;
        if4.Key = '0; if6.Key = '0; if8.Key = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_ks", {127'b0, |if4.keySchedule}, 128'h0);
            check("idle_busy_done", {126'b0, if4.busy, if4.done}, 128'h0);
        end

        // FIPS-197 AES-128 example key.
        k = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        issue(4, k, 1'b1);
        check("accept_busy_done", {126'b0, if4.busy, if4.done}, 128'h2);
        check("key_words", if4.keySchedule[0 +: 128], k[255 -: 128]);
        @(posedge clk); #1;
        check("word4", if4.keySchedule[128 +: 32], 128'ha0fafe17);
        wait_done(4, 60);
        check("rk10_fips", if4.keySchedule[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        repeat (5) @(negedge clk);
        check("done_hold", {126'b0, if4.busy, if4.done}, 128'h1);
        check("rk10_hold", if4.keySchedule[1280 +: 128], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Restart from DONE.
        issue(4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0}, 1'b1);
        check("restart_busy_done", {126'b0, if4.busy, if4.done}, 128'h2);
        wait_done(4, 60);
        check("rk10_seq", if4.keySchedule[1280 +: 128], 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // Start during RUN at k+5 is ignored.
        issue(4, rand_key(), 1'b1);
        repeat (4) @(posedge clk);
        issue(4, rand_key(), 1'b0);
        wait_done(4, 60);

        // Reset mid-run at k+20.
        issue(4, rand_key(), 1'b1);
        repeat (19) @(posedge clk);
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        q4.delete(); q6.delete(); q8.delete();
        check("rst_ks", {127'b0, |if4.keySchedule}, 128'h0);
        check("rst_busy_done", {126'b0, if4.busy, if4.done}, 128'h0);

        // Reset wins over a simultaneous start.
        @(negedge clk); reset = 1'b1; if4.start = 1'b1;
        @(posedge clk); #1 reset = 1'b0; if4.start = 1'b0;
        check("rst_prio", {125'b0, if4.busy, if4.done, |if4.keySchedule}, 128'h0);

        // Random keys, each restarted from DONE.
        for (int i = 0; i < 5; i++) begin
            issue(4, rand_key(), 1'b1);
            check("rand_accept", {126'b0, if4.busy, if4.done}, 128'h2);
            wait_done(4, 60);
        end

        // AES-192 and AES-256 sweeps.
        issue(6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0}, 1'b1);
        wait_done(6, 70);
        check("rk12", if6.keySchedule[1536 +: 128], 128'ha4970a331a78dc09c418c271e3a41d5d);
        for (int i = 0; i < 2; i++) begin
            issue(6, rand_key(), 1'b1);
            wait_done(6, 70);
        end
        issue(8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f, 1'b1);
        wait_done(8, 70);
        check("rk14", if8.keySchedule[1792 +: 128], 128'h24fc79ccbf0979e9371ac23c6d68de36);
        for (int i = 0; i < 2; i++) begin
            issue(8, rand_key(), 1'b1);
            wait_done(8, 70);
        end

        repeat (3) @(negedge clk);
        check("pending", q4.size() + q6.size() + q8.size(), 128'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
